// File: rtl/alu_operand_writeback.sv
// Operand-fetch / writeback stage around a combinational ALU: register file, flags register,
// one-entry execute slot with result forwarding, and a retired-instruction counter.
module alu_operand_writeback #(
    parameter int unsigned DataWidth    = 16,
    parameter int unsigned RegCount     = 8,
    parameter int unsigned RegAddrWidth = 3,
    parameter int unsigned FlagWidth    = 5,
    parameter int unsigned CountWidth   = 16
) (
    input  logic                    Clock,
    input  logic                    nReset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [RegAddrWidth-1:0] InSrcSel,
    input  logic [RegAddrWidth-1:0] InDestSel,
    input  logic                    InRegWrite,
    input  logic                    InFlagWrite,
    input  logic                    Hold,
    output logic                    AluValid,
    output logic [DataWidth-1:0]    AluSrc,
    output logic [DataWidth-1:0]    AluDest,
    output logic [FlagWidth-1:0]    AluFlags,
    input  logic [DataWidth-1:0]    AluResult,
    input  logic [FlagWidth-1:0]    AluOutFlags,
    input  logic [RegAddrWidth-1:0] DbgSel,
    output logic [DataWidth-1:0]    DbgData,
    output logic [FlagWidth-1:0]    FlagsOut,
    output logic [CountWidth-1:0]   RetiredCount
);

    logic [DataWidth-1:0]    reg_q [RegCount];
    logic [FlagWidth-1:0]    flags_q;
    logic [CountWidth-1:0]   retired_q;

    logic                    slot_valid_q, slot_valid_d;
    logic [RegAddrWidth-1:0] slot_dest_q, slot_dest_d;
    logic                    slot_reg_write_q, slot_reg_write_d;
    logic                    slot_flag_write_q, slot_flag_write_d;
    logic [DataWidth-1:0]    alu_src_q, alu_src_d;
    logic [DataWidth-1:0]    alu_dest_q, alu_dest_d;
    logic [FlagWidth-1:0]    alu_flags_q, alu_flags_d;

    logic                    accept;
    logic                    retire;
    logic                    reg_wb;
    logic [DataWidth-1:0]    src_rd, dest_rd;

    function automatic logic sel_in_range(input logic [RegAddrWidth-1:0] sel);
        return 32'(sel) < RegCount;
    endfunction

    assign InReady = !(slot_valid_q && Hold);
    assign accept  = InValid && InReady;
    assign retire  = slot_valid_q && !Hold;
    // Out-of-range destinations are dropped, so they must not forward either.
    assign reg_wb  = retire && slot_reg_write_q && sel_in_range(slot_dest_q);

    always_comb begin
        src_rd  = '0;
        dest_rd = '0;
        DbgData = '0;
        if (sel_in_range(InSrcSel)) begin
            src_rd = reg_q[InSrcSel];
        end
        if (sel_in_range(InDestSel)) begin
            dest_rd = reg_q[InDestSel];
        end
        if (sel_in_range(DbgSel)) begin
            DbgData = reg_q[DbgSel];
        end
    end

    always_comb begin
        slot_valid_d      = slot_valid_q;
        slot_dest_d       = slot_dest_q;
        slot_reg_write_d  = slot_reg_write_q;
        slot_flag_write_d = slot_flag_write_q;
        alu_src_d         = alu_src_q;
        alu_dest_d        = alu_dest_q;
        alu_flags_d       = alu_flags_q;
        if (accept) begin
            slot_valid_d      = 1'b1;
            slot_dest_d       = InDestSel;
            slot_reg_write_d  = InRegWrite;
            slot_flag_write_d = InFlagWrite;
            alu_src_d         = (reg_wb && InSrcSel == slot_dest_q) ? AluResult : src_rd;
            alu_dest_d        = (reg_wb && InDestSel == slot_dest_q) ? AluResult : dest_rd;
            alu_flags_d       = (retire && slot_flag_write_q) ? AluOutFlags : flags_q;
        end else if (retire) begin
            slot_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < RegCount; i++) begin
                reg_q[i] <= '0;
            end
            flags_q           <= '0;
            retired_q         <= '0;
            slot_valid_q      <= 1'b0;
            slot_dest_q       <= '0;
            slot_reg_write_q  <= 1'b0;
            slot_flag_write_q <= 1'b0;
            alu_src_q         <= '0;
            alu_dest_q        <= '0;
            alu_flags_q       <= '0;
        end else begin
            for (int unsigned i = 0; i < RegCount; i++) begin
                if (reg_wb && slot_dest_q == RegAddrWidth'(i)) begin
                    reg_q[i] <= AluResult;
                end
            end
            if (retire && slot_flag_write_q) begin
                flags_q <= AluOutFlags;
            end
            if (retire) begin
                retired_q <= retired_q + CountWidth'(1);
            end
            slot_valid_q      <= slot_valid_d;
            slot_dest_q       <= slot_dest_d;
            slot_reg_write_q  <= slot_reg_write_d;
            slot_flag_write_q <= slot_flag_write_d;
            alu_src_q         <= alu_src_d;
            alu_dest_q        <= alu_dest_d;
            alu_flags_q       <= alu_flags_d;
        end
    end

    assign AluValid     = slot_valid_q;
    assign AluSrc       = alu_src_q;
    assign AluDest      = alu_dest_q;
    assign AluFlags     = alu_flags_q;
    assign FlagsOut     = flags_q;
    assign RetiredCount = retired_q;

endmodule

// File: tb/tb_alu_operand_writeback.sv
// Directed bench for alu_operand_writeback; the bench plays the ALU by driving AluResult and
// AluOutFlags with hand-picked values during each execute cycle.
module tb_alu_operand_writeback;

    logic        Clock;
    logic        nReset;
    logic        InValid;
    logic        InReady;
    logic [2:0]  InSrcSel;
    logic [2:0]  InDestSel;
    logic        InRegWrite;
    logic        InFlagWrite;
    logic        Hold;
    logic        AluValid;
    logic [15:0] AluSrc;
    logic [15:0] AluDest;
    logic [4:0]  AluFlags;
    logic [15:0] AluResult;
    logic [4:0]  AluOutFlags;
    logic [2:0]  DbgSel;
    logic [15:0] DbgData;
    logic [4:0]  FlagsOut;
    logic [15:0] RetiredCount;

    int errors;
    int checks;

    alu_operand_writeback dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .InValid      (InValid),
        .InReady      (InReady),
        .InSrcSel     (InSrcSel),
        .InDestSel    (InDestSel),
        .InRegWrite   (InRegWrite),
        .InFlagWrite  (InFlagWrite),
        .Hold         (Hold),
        .AluValid     (AluValid),
        .AluSrc       (AluSrc),
        .AluDest      (AluDest),
        .AluFlags     (AluFlags),
        .AluResult    (AluResult),
        .AluOutFlags  (AluOutFlags),
        .DbgSel       (DbgSel),
        .DbgData      (DbgData),
        .FlagsOut     (FlagsOut),
        .RetiredCount (RetiredCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Accept one instruction, then retire it with the given ALU outputs.
    task automatic issue(input logic [2:0] src, input logic [2:0] dest, input logic rw,
                         input logic fw, input logic [15:0] result, input logic [4:0] flags);
        InSrcSel    = src;
        InDestSel   = dest;
        InRegWrite  = rw;
        InFlagWrite = fw;
        InValid     = 1'b1;
        tick();
        InValid     = 1'b0;
        AluResult   = result;
        AluOutFlags = flags;
        tick();
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        InValid = 1'b0; InSrcSel = '0; InDestSel = '0; InRegWrite = 1'b0; InFlagWrite = 1'b0;
        Hold = 1'b0; AluResult = '0; AluOutFlags = '0; DbgSel = '0;
        tick();
        tick();
        nReset = 1'b1;
        repeat (5) tick();
        checks++;
        if (InReady !== 1'b1) begin
            errors++; $display("FAIL reset_inready: got %b want 1", InReady);
        end
        checks++;
        if (AluValid !== 1'b0) begin
            errors++; $display("FAIL reset_aluvalid: got %b want 0", AluValid);
        end
        checks++;
        if (FlagsOut !== 5'h00) begin
            errors++; $display("FAIL reset_flags: got %h want 00", FlagsOut);
        end
        checks++;
        if (RetiredCount !== 16'h0000) begin
            errors++; $display("FAIL reset_count: got %h want 0000", RetiredCount);
        end
        checks++;
        if ({AluSrc, AluDest, AluFlags} !== 37'h0) begin
            errors++; $display("FAIL reset_aluin: got %h/%h/%h want 0", AluSrc, AluDest, AluFlags);
        end
        for (int i = 0; i < 8; i++) begin
            DbgSel = 3'(i);
            #1;
            checks++;
            if (DbgData !== 16'h0000) begin
                errors++; $display("FAIL reset_reg%0d: got %h want 0000", i, DbgData);
            end
        end
    endtask

    task automatic test_single_write();
        issue(3'd0, 3'd2, 1'b1, 1'b0, 16'h0005, 5'b00000);
        InSrcSel = 3'd2; InDestSel = 3'd3; InRegWrite = 1'b1; InFlagWrite = 1'b0;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        AluResult = 16'h1234; AluOutFlags = 5'b00001;
        DbgSel = 3'd3;
        #1;
        checks++;
        if (AluValid !== 1'b1 || AluSrc !== 16'h0005 || AluDest !== 16'h0000) begin
            errors++;
            $display("FAIL single_operands: got v=%b src=%h dst=%h want v=1 src=0005 dst=0000",
                     AluValid, AluSrc, AluDest);
        end
        checks++;
        if (DbgData !== 16'h0000) begin
            errors++; $display("FAIL single_precommit: got %h want 0000", DbgData);
        end
        tick();
        checks++;
        if (DbgData !== 16'h1234) begin
            errors++; $display("FAIL single_commit: got %h want 1234", DbgData);
        end
        checks++;
        if (FlagsOut !== 5'b00000) begin
            errors++; $display("FAIL single_flags: got %b want 00000", FlagsOut);
        end
        checks++;
        if (RetiredCount !== 16'd2 || AluValid !== 1'b0) begin
            errors++;
            $display("FAIL single_count: got cnt=%0d v=%b want cnt=2 v=0", RetiredCount, AluValid);
        end
    endtask

    task automatic test_back_to_back();
        // A: r1 <= 00FF, flags <= 10000; B (src=dst=r1) accepted on A's retiring edge.
        InSrcSel = 3'd0; InDestSel = 3'd1; InRegWrite = 1'b1; InFlagWrite = 1'b1;
        InValid = 1'b1;
        tick();
        AluResult = 16'h00FF; AluOutFlags = 5'b10000;
        InSrcSel = 3'd1; InDestSel = 3'd1; InRegWrite = 1'b1; InFlagWrite = 1'b0;
        tick();
        InValid = 1'b0;
        checks++;
        if (AluSrc !== 16'h00FF || AluDest !== 16'h00FF) begin
            errors++; $display("FAIL b2b_fwd_data: got %h/%h want 00FF/00FF", AluSrc, AluDest);
        end
        checks++;
        if (AluFlags !== 5'b10000) begin
            errors++; $display("FAIL b2b_fwd_flags: got %b want 10000", AluFlags);
        end
        checks++;
        if (FlagsOut !== 5'b10000) begin
            errors++; $display("FAIL b2b_flags_commit: got %b want 10000", FlagsOut);
        end
        AluResult = 16'h0100; AluOutFlags = 5'b00000;
        tick();
        DbgSel = 3'd1;
        #1;
        checks++;
        if (DbgData !== 16'h0100 || FlagsOut !== 5'b10000 || RetiredCount !== 16'd4) begin
            errors++;
            $display("FAIL b2b_commit: got r1=%h f=%b cnt=%0d want 0100 10000 4",
                     DbgData, FlagsOut, RetiredCount);
        end
        // C writes nothing; D reading C's dest must see the register file, not AluResult.
        InSrcSel = 3'd0; InDestSel = 3'd5; InRegWrite = 1'b0; InFlagWrite = 1'b0;
        InValid = 1'b1;
        tick();
        AluResult = 16'hAAAA; AluOutFlags = 5'b00110;
        InSrcSel = 3'd5; InDestSel = 3'd2; InRegWrite = 1'b1; InFlagWrite = 1'b0;
        tick();
        InValid = 1'b0;
        checks++;
        if (AluSrc !== 16'h0000 || AluDest !== 16'h0005 || AluFlags !== 5'b10000) begin
            errors++;
            $display("FAIL nofwd: got %h/%h/%b want 0000/0005/10000", AluSrc, AluDest, AluFlags);
        end
        AluResult = 16'h0055;
        tick();
        DbgSel = 3'd2;
        #1;
        checks++;
        if (DbgData !== 16'h0055 || RetiredCount !== 16'd6) begin
            errors++;
            $display("FAIL nofwd_commit: got r2=%h cnt=%0d want 0055 6", DbgData, RetiredCount);
        end
    endtask

    task automatic test_hold();
        Hold = 1'b1;
        InSrcSel = 3'd1; InDestSel = 3'd6; InRegWrite = 1'b1; InFlagWrite = 1'b0;
        InValid = 1'b1;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            errors++; $display("FAIL hold_empty_ready: got %b want 1", InReady);
        end
        tick();
        checks++;
        if (AluValid !== 1'b1 || AluSrc !== 16'h0100 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept: got v=%b src=%h rdy=%b want 1 0100 0",
                     AluValid, AluSrc, InReady);
        end
        InSrcSel = 3'd6; InDestSel = 3'd7;
        AluResult = 16'h6666; AluOutFlags = 5'b11111;
        DbgSel = 3'd6;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (InReady !== 1'b0 || AluValid !== 1'b1 || AluSrc !== 16'h0100 ||
                DbgData !== 16'h0000 || RetiredCount !== 16'd6 || FlagsOut !== 5'b10000) begin
                errors++;
                $display("FAIL hold_frozen%0d: rdy=%b v=%b src=%h r6=%h cnt=%0d f=%b", c,
                         InReady, AluValid, AluSrc, DbgData, RetiredCount, FlagsOut);
            end
        end
        Hold = 1'b0;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            errors++; $display("FAIL hold_release_ready: got %b want 1", InReady);
        end
        tick();
        InValid = 1'b0;
        checks++;
        if (AluSrc !== 16'h6666 || AluDest !== 16'h0000 || AluFlags !== 5'b10000 ||
            DbgData !== 16'h6666 || RetiredCount !== 16'd7) begin
            errors++;
            $display("FAIL hold_release: src=%h dst=%h af=%b r6=%h cnt=%0d want 6666 0 10000 6666 7",
                     AluSrc, AluDest, AluFlags, DbgData, RetiredCount);
        end
        AluResult = 16'h7777;
        tick();
        DbgSel = 3'd7;
        #1;
        checks++;
        if (DbgData !== 16'h7777 || RetiredCount !== 16'd8) begin
            errors++;
            $display("FAIL hold_second: got r7=%h cnt=%0d want 7777 8", DbgData, RetiredCount);
        end
    endtask

    task automatic test_counter_wrap();
        int k;
        k = 65536 - 8;
        InSrcSel = 3'd0; InDestSel = 3'd6; InRegWrite = 1'b0; InFlagWrite = 1'b0;
        AluResult = 16'hDEAD; AluOutFlags = 5'b01010;
        InValid = 1'b1;
        for (int i = 0; i < k; i++) begin
            tick();
        end
        checks++;
        if (RetiredCount !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_max: got %h want FFFF", RetiredCount);
        end
        InValid = 1'b0;
        tick();
        DbgSel = 3'd6;
        #1;
        checks++;
        if (RetiredCount !== 16'h0000 || AluValid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero: got cnt=%h v=%b want 0000 0", RetiredCount, AluValid);
        end
        checks++;
        if (DbgData !== 16'h6666 || FlagsOut !== 5'b10000) begin
            errors++;
            $display("FAIL wrap_nowrite: got r6=%h f=%b want 6666 10000", DbgData, FlagsOut);
        end
    endtask

    task automatic test_reset_midflight();
        InSrcSel = 3'd6; InDestSel = 3'd4; InRegWrite = 1'b1; InFlagWrite = 1'b1;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        AluResult = 16'hBEEF; AluOutFlags = 5'b11111;
        DbgSel = 3'd6;
        #1;
        nReset = 1'b0;
        #1;
        checks++;
        if (AluValid !== 1'b0 || AluSrc !== 16'h0000 || RetiredCount !== 16'h0000 ||
            DbgData !== 16'h0000 || FlagsOut !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_async: v=%b src=%h cnt=%h r6=%h f=%b want all 0",
                     AluValid, AluSrc, RetiredCount, DbgData, FlagsOut);
        end
        #2;
        nReset = 1'b1;
        tick();
        DbgSel = 3'd4;
        #1;
        checks++;
        if (DbgData !== 16'h0000 || AluValid !== 1'b0 || RetiredCount !== 16'h0000 ||
            FlagsOut !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_discard: r4=%h v=%b cnt=%h f=%b want 0 0 0 0",
                     DbgData, AluValid, RetiredCount, FlagsOut);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_hold();
        test_counter_wrap();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
